// File: rtl/piso_stream_serializer.sv
// Parallel-in serial-out serializer: valid/ready word input, one-word holding buffer,
// LANES bits per beat, LSB- or MSB-first, gapless streaming between words.
module piso_stream_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [LANES-1:0]      dout,
    output logic                  dout_valid,
    output logic                  dout_first,
    output logic                  dout_last,
    output logic                  busy
);

    localparam int BEATS = DATA_WIDTH / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] sreg, sreg_nxt;
    logic [DATA_WIDTH-1:0] hold, hold_nxt;
    logic                  hold_valid, hold_valid_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  accept;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] shifted;

    assign accept    = din_valid && !hold_valid;
    assign last_beat = (cnt == LAST_CNT);
    // The output end is the low bits for LSB-first, the high bits for MSB-first.
    assign shifted   = MSB_FIRST ? (sreg << LANES) : (sreg >> LANES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sreg       <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            hold       <= hold_nxt;
            hold_valid <= hold_valid_nxt;
            cnt        <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sreg_nxt       = sreg;
        hold_nxt       = hold;
        hold_valid_nxt = hold_valid;
        cnt_nxt        = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_nxt  = din;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_beat) begin
                    sreg_nxt = shifted;
                    cnt_nxt  = cnt + CW'(1);
                    if (accept) begin
                        hold_nxt       = din;
                        hold_valid_nxt = 1'b1;
                    end
                end else if (hold_valid) begin
                    // Buffered word takes priority; din_ready is low so nothing new arrives.
                    sreg_nxt       = hold;
                    cnt_nxt        = '0;
                    hold_valid_nxt = 1'b0;
                end else if (accept) begin
                    sreg_nxt = din;
                    cnt_nxt  = '0;
                end else begin
                    sreg_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == SHIFT);
        dout_valid = busy;
        dout_first = busy && (cnt == '0);
        dout_last  = busy && last_beat;
        din_ready  = !hold_valid;
        dout       = '0;
        if (busy) begin
            dout = MSB_FIRST ? sreg[DATA_WIDTH-1 -: LANES] : sreg[LANES-1:0];
        end
    end

endmodule
